srt_div_ctrl: RTL and testbench

SRT_DIV_CTRL -- requirements
Module: srt_div_ctrl

---
 rtl/srt_div_ctrl.sv | 157 +++++++++++++++
 tb/tb_srt_div_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srt_div_ctrl.sv
// Sequencer for an iterative radix-4 SRT single-precision divider: request/result handshakes and datapath load/step pulses.
// Compile-time option SRT_DIV_CTRL_SPECIAL_EN resolves IEEE special operands in the controller without touching the datapath.
module srt_div_ctrl #(
   parameter int unsigned ITERS = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] quotient,
   output logic [1:0]  exc,
   output logic        dp_load,
   output logic        dp_step,
   output logic [31:0] dp_dividend,
   output logic [31:0] dp_divisor,
   input  logic [31:0] dp_result
);

   typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_e;

   localparam logic [4:0] ITERS_M1 = 5'(ITERS - 1);

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic [31:0] quo_q, quo_d;
   logic        accept;
   logic        iter_last;

   assign accept    = in_valid && (state_q == IDLE);
   assign iter_last = (state_q == ITER) && (cnt_q == 5'd0);

`ifdef SRT_DIV_CTRL_SPECIAL_EN
   logic [1:0]  exc_q, exc_d;
   logic        spec_hit;
   logic [31:0] spec_quo;
   logic [1:0]  spec_exc;
   logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sgn;

   // Denormals fall through as nonzero finite: only exp==0 with mantissa==0 is zero.
   always_comb begin
      a_nan  = (&dividend[30:23]) && (|dividend[22:0]);
      a_inf  = (&dividend[30:23]) && !(|dividend[22:0]);
      a_zero = !(|dividend[30:0]);
      b_nan  = (&divisor[30:23]) && (|divisor[22:0]);
      b_inf  = (&divisor[30:23]) && !(|divisor[22:0]);
      b_zero = !(|divisor[30:0]);
      sgn    = dividend[31] ^ divisor[31];
      spec_hit = 1'b1;
      spec_quo = '0;
      spec_exc = 2'b00;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_quo = 32'h7FC0_0000;
         spec_exc = 2'b10;
      end else if (b_zero) begin
         spec_quo = {sgn, 8'hFF, 23'h0};
         spec_exc = 2'b01;
      end else if (a_inf) begin
         spec_quo = {sgn, 8'hFF, 23'h0};
      end else if (a_zero || b_inf) begin
         spec_quo = {sgn, 31'h0};
      end else begin
         spec_hit = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         quo_q   <= '0;
`ifdef SRT_DIV_CTRL_SPECIAL_EN
         exc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         quo_q   <= quo_d;
`ifdef SRT_DIV_CTRL_SPECIAL_EN
         exc_q   <= exc_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
`ifdef SRT_DIV_CTRL_SPECIAL_EN
               state_d = spec_hit ? DONE : LOAD;
`else
               state_d = LOAD;
`endif
            end
         end
         LOAD: begin
            state_d = ITER;
            cnt_d   = ITERS_M1;
         end
         ITER: begin
            if (cnt_q == 5'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 5'd1;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      opa_d = opa_q;
      opb_d = opb_q;
      quo_d = quo_q;
      if (accept) begin
         opa_d = dividend;
         opb_d = divisor;
      end
      if (iter_last) quo_d = dp_result;
`ifdef SRT_DIV_CTRL_SPECIAL_EN
      exc_d = exc_q;
      if (iter_last) exc_d = 2'b00;
      if (accept && spec_hit) begin
         quo_d = spec_quo;
         exc_d = spec_exc;
      end
`endif
   end

   always_comb begin
      in_ready    = (state_q == IDLE);
      out_valid   = (state_q == DONE);
      dp_load     = (state_q == LOAD);
      dp_step     = (state_q == ITER);
      dp_dividend = opa_q;
      dp_divisor  = opb_q;
      quotient    = quo_q;
`ifdef SRT_DIV_CTRL_SPECIAL_EN
      exc         = exc_q;
`else
      exc         = 2'b00;
`endif
   end

endmodule

// File: tb/tb_srt_div_ctrl.sv
// Randomised bench for srt_div_ctrl with a behavioural datapath and reference divide/special-case models.
// Special-case tests are built when SRT_DIV_CTRL_SPECIAL_EN is defined; otherwise the pass-through behaviour is tested.
module tb_srt_div_ctrl;

   localparam int unsigned ITERS = 14;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] quotient;
   logic [1:0]  exc;
   logic        dp_load;
   logic        dp_step;
   logic [31:0] dp_dividend;
   logic [31:0] dp_divisor;
   logic [31:0] dp_result;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   srt_div_ctrl #(.ITERS(ITERS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient), .exc(exc),
      .dp_load(dp_load), .dp_step(dp_step), .dp_dividend(dp_dividend), .dp_divisor(dp_divisor),
      .dp_result(dp_result)
   );

   // Reference quotient: exact real division truncated back to single for normal operands, a fixed mix otherwise.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] da, db, dq;
      real ra, rb;
      if (a[30:23] inside {[8'd1:8'd254]} && b[30:23] inside {[8'd1:8'd254]}) begin
         da = {a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'h0};
         db = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'h0};
         ra = $bitstoreal(da);
         rb = $bitstoreal(db);
         dq = $realtobits(ra / rb);
         return {dq[63], 8'(int'(dq[62:52]) - 896), dq[51:29]};
      end
      return a ^ {b[15:0], b[31:16]};
   endfunction

   // Datapath model: result is only presented during the last of ITERS step cycles after a load.
   logic [31:0] m_a = '0, m_b = '0;
   int          m_steps = 0;
   always @(posedge clk) begin
      if (dp_load) begin
         m_a <= dp_dividend;
         m_b <= dp_divisor;
         m_steps <= 0;
      end else if (dp_step) begin
         m_steps <= m_steps + 1;
      end
   end
   assign dp_result = (dp_step && m_steps == int'(ITERS) - 1) ? ref_div(m_a, m_b) : 32'hDEAD_BEEF;

   function automatic logic [31:0] rand_normal();
      return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
   endfunction

   // Issues one request and samples #1 after each edge; cycle 1 is the one after the accepting edge.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int loads, output int steps, output int both);
      lat = -1; loads = 0; steps = 0; both = 0;
      @(negedge clk);
      dividend = a; divisor = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; dividend = $urandom; divisor = $urandom;
      for (int k = 1; k <= 100; k++) begin
         if (dp_load) loads++;
         if (dp_step) steps++;
         if (dp_load && dp_step) both++;
         if (out_valid) begin
            lat = k;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic finish_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, out_valid, dp_load, dp_step} !== 4'b1000) begin
         n_err++; $display("FAIL reset_ctrl: got %b expected 1000", {in_ready, out_valid, dp_load, dp_step});
      end
      n_cmp++;
      if ({quotient, exc, dp_dividend, dp_divisor} !== 98'h0) begin
         n_err++; $display("FAIL reset_data: got q=%h exc=%b a=%h b=%h expected zeros", quotient, exc, dp_dividend, dp_divisor);
      end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_normal();
      int lat, loads, steps, both;
      run_div(32'h40C0_0000, 32'h4000_0000, lat, loads, steps, both);
      n_cmp++;
      if (lat !== int'(ITERS) + 2) begin n_err++; $display("FAIL normal_latency: got %0d expected %0d", lat, ITERS + 2); end
      n_cmp++;
      if (loads !== 1 || steps !== int'(ITERS) || both !== 0) begin
         n_err++; $display("FAIL normal_pulses: got load=%0d step=%0d both=%0d expected 1/%0d/0", loads, steps, both, ITERS);
      end
      n_cmp++;
      if (quotient !== 32'h4040_0000 || exc !== 2'b00) begin
         n_err++; $display("FAIL normal_result: got %h/%b expected 40400000/00", quotient, exc);
      end
      n_cmp++;
      if (dp_dividend !== 32'h40C0_0000 || dp_divisor !== 32'h4000_0000) begin
         n_err++; $display("FAIL normal_operands_held: got %h/%h expected 40c00000/40000000", dp_dividend, dp_divisor);
      end
      finish_out();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL normal_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_random();
      int lat, loads, steps, both;
      logic [31:0] a, b, exp_q;
      for (int i = 0; i < 20; i++) begin
         a = rand_normal();
         b = rand_normal();
         exp_q = ref_div(a, b);
         run_div(a, b, lat, loads, steps, both);
         n_cmp++;
         if (lat !== int'(ITERS) + 2 || quotient !== exp_q || exc !== 2'b00) begin
            n_err++;
            $display("FAIL random_div %h/%h: got lat=%0d q=%h exc=%b expected lat=%0d q=%h exc=00",
                     a, b, lat, quotient, exc, ITERS + 2, exp_q);
         end
         finish_out();
      end
   endtask

   task automatic test_backpressure();
      int lat, loads, steps, both;
      out_ready = 1'b0;
      run_div(32'h4120_0000, 32'h40A0_0000, lat, loads, steps, both);
      n_cmp++;
      if (lat !== int'(ITERS) + 2) begin n_err++; $display("FAIL bp_latency: got %0d expected %0d", lat, ITERS + 2); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; dividend = 32'h4040_0000; divisor = 32'h3F80_0000;
         @(posedge clk); #1;
         in_valid = 1'b0;
         n_cmp++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'h4000_0000 || exc !== 2'b00
             || dp_load !== 1'b0 || dp_dividend !== 32'h4120_0000) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: got ov=%b ir=%b q=%h exc=%b load=%b a=%h expected 1/0/40000000/00/0/41200000",
                     i, out_valid, in_ready, quotient, exc, dp_load, dp_dividend);
         end
      end
      finish_out();
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || dp_load !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_no_queue: got ov=%b load=%b ir=%b expected 0/0/1", out_valid, dp_load, in_ready);
      end
   endtask

   task automatic test_reset_abort();
      int lat, loads, steps, both;
      bit  seen_ov;
      @(negedge clk);
      dividend = 32'h40C0_0000; divisor = 32'h4000_0000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) begin @(posedge clk); #1; end
      n_cmp++;
      if (dp_step !== 1'b1) begin n_err++; $display("FAIL abort_in_iter: got dp_step=%b expected 1", dp_step); end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, out_valid, dp_load, dp_step} !== 4'b1000 || {quotient, exc, dp_dividend, dp_divisor} !== 98'h0) begin
         n_err++;
         $display("FAIL abort_reset_values: got ctl=%b q=%h exc=%b a=%h b=%h expected 1000 and zeros",
                  {in_ready, out_valid, dp_load, dp_step}, quotient, exc, dp_dividend, dp_divisor);
      end
      seen_ov = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (out_valid) seen_ov = 1'b1; end
      @(negedge clk); rst = 1'b1;
      repeat (18) begin @(posedge clk); #1; if (out_valid) seen_ov = 1'b1; end
      n_cmp++;
      if (seen_ov !== 1'b0) begin n_err++; $display("FAIL abort_no_result: got out_valid=1 expected 0"); end
      run_div(32'h40C0_0000, 32'h4000_0000, lat, loads, steps, both);
      n_cmp++;
      if (lat !== int'(ITERS) + 2 || quotient !== 32'h4040_0000 || loads !== 1) begin
         n_err++; $display("FAIL abort_fresh_div: got lat=%0d q=%h loads=%0d expected %0d/40400000/1", lat, quotient, loads, ITERS + 2);
      end
      finish_out();
   endtask

`ifdef SRT_DIV_CTRL_SPECIAL_EN
   // Operand class: 0 zero, 1 finite nonzero (incl. denormal), 2 infinity, 3 NaN.
   function automatic int fclass(input logic [31:0] x);
      if (x[30:23] == 8'hFF) return (x[22:0] != 0) ? 3 : 2;
      if (x[30:0] == 0) return 0;
      return 1;
   endfunction

   function automatic logic [31:0] make_class(input int c);
      case (c)
         0:       return {1'($urandom), 31'h0};
         1:       return {1'($urandom), 8'($urandom_range(254, 0)), 23'($urandom) | 23'h1};
         2:       return {1'($urandom), 8'hFF, 23'h0};
         default: return {1'($urandom), 8'hFF, 23'($urandom) | 23'h1};
      endcase
   endfunction

   task automatic ref_special(input logic [31:0] a, input logic [31:0] b,
                              output bit hit, output logic [31:0] q, output logic [1:0] e);
      int ca = fclass(a), cb = fclass(b);
      bit s = a[31] ^ b[31];
      hit = 1'b1; e = 2'b00;
      if (ca == 3 || cb == 3 || (ca == 0 && cb == 0) || (ca == 2 && cb == 2)) begin q = 32'h7FC0_0000; e = 2'b10; end
      else if (cb == 0)            begin q = {s, 8'hFF, 23'h0}; e = 2'b01; end
      else if (ca == 2)            q = {s, 8'hFF, 23'h0};
      else if (ca == 0 || cb == 2) q = {s, 31'h0};
      else begin hit = 1'b0; q = ref_div(a, b); end
   endtask

   task automatic test_special();
      int lat, loads, steps, both;
      logic [31:0] ta [11] = '{32'h3F80_0000, 32'h7FC0_0001, 32'hBF80_0000, 32'h0000_0000, 32'h7F80_0000,
                               32'hFF80_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h7F80_0000, 32'h3F80_0000};
      logic [31:0] tb [11] = '{32'h0000_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h8000_0000, 32'hFF80_0000,
                               32'h4000_0000, 32'h4040_0000, 32'h8000_0000, 32'h0000_0001, 32'h0040_0000, 32'h7F80_0001};
      logic [31:0] tq [11] = '{32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                               32'hFF80_0000, 32'h8000_0000, 32'hFF80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000};
      logic [1:0]  te [11] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
      for (int i = 0; i < 11; i++) begin
         run_div(ta[i], tb[i], lat, loads, steps, both);
         n_cmp++;
         if (lat !== 1 || loads !== 0 || steps !== 0 || quotient !== tq[i] || exc !== te[i]) begin
            n_err++;
            $display("FAIL special_table[%0d] %h/%h: got lat=%0d load=%0d step=%0d q=%h exc=%b expected 1/0/0/%h/%b",
                     i, ta[i], tb[i], lat, loads, steps, quotient, exc, tq[i], te[i]);
         end
         finish_out();
      end
   endtask

   task automatic test_special_random();
      int lat, loads, steps, both, exp_lat;
      bit hit;
      logic [31:0] a, b, q;
      logic [1:0]  e;
      for (int i = 0; i < 24; i++) begin
         a = make_class(int'($urandom_range(3, 0)));
         b = make_class(int'($urandom_range(3, 0)));
         ref_special(a, b, hit, q, e);
         exp_lat = hit ? 1 : int'(ITERS) + 2;
         run_div(a, b, lat, loads, steps, both);
         n_cmp++;
         if (lat !== exp_lat || loads !== (hit ? 0 : 1) || quotient !== q || exc !== e) begin
            n_err++;
            $display("FAIL special_random %h/%h: got lat=%0d load=%0d q=%h exc=%b expected %0d/%0d/%h/%b",
                     a, b, lat, loads, quotient, exc, exp_lat, hit ? 0 : 1, q, e);
         end
         finish_out();
      end
   endtask
`else
   task automatic test_no_special();
      int lat, loads, steps, both;
      logic [31:0] ta [3] = '{32'h3F80_0000, 32'h7FC0_0001, 32'h0000_0000};
      logic [31:0] tb [3] = '{32'h0000_0000, 32'h3F80_0000, 32'h0000_0000};
      for (int i = 0; i < 3; i++) begin
         run_div(ta[i], tb[i], lat, loads, steps, both);
         n_cmp++;
         if (lat !== int'(ITERS) + 2 || loads !== 1 || steps !== int'(ITERS) || quotient !== ref_div(ta[i], tb[i]) || exc !== 2'b00) begin
            n_err++;
            $display("FAIL nospecial[%0d] %h/%h: got lat=%0d load=%0d step=%0d q=%h exc=%b expected %0d/1/%0d/%h/00",
                     i, ta[i], tb[i], lat, loads, steps, quotient, exc, ITERS + 2, ITERS, ref_div(ta[i], tb[i]));
         end
         finish_out();
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_normal();
      test_random();
      test_backpressure();
      test_reset_abort();
`ifdef SRT_DIV_CTRL_SPECIAL_EN
      test_special();
      test_special_random();
`else
      test_no_special();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
